// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the instruction/data memory port arbiter.
//   arb_state_t : FSM encoding (IDLE, ACCESS, DONE)
//   PORT_I/D    : id of the requester that won the current transaction
//   CNT_W       : width of the starvation counter (holds limits up to 15)
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// ---------------------------------------------------------------------------
// arb_starve_counter
// Counts how many arbitrations in a row the instruction port has lost.
// Saturates at STARVE_LIMIT; once there, 'starved' forces the next
// arbitration in favour of the instruction port.
// Ports:
//   Clk, Reset : clock, synchronous active-high reset
//   clr        : instruction port was granted, restart the count
//   inc        : instruction port was waiting and lost to the data port
//   starved    : count has reached STARVE_LIMIT
// ---------------------------------------------------------------------------
module arb_starve_counter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr,
  input  logic inc,
  output logic starved
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt;

  // The clear wins over the increment because both come from the same
  // arbitration decision and a grant to the instruction port is what
  // the counter exists to produce. Saturation keeps 'starved' asserted
  // until that grant actually happens.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign starved = (cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port unified memory between instruction fetch (I) and
// load/store (D). A request is latched in IDLE, drives the memory for one
// ACCESS cycle, and is acknowledged with a one-cycle pulse in DONE together
// with the registered read data. D has priority; a starvation counter hands
// the memory to I after STARVE_LIMIT consecutive lost arbitrations.
// Ports:
//   Clk, Reset                  : clock, synchronous active-high reset
//   i_req, i_addr               : fetch request and address
//   i_ack, i_rdata              : fetch acknowledge pulse and fetched word
//   d_req, d_we, d_addr, d_wdata: load/store request, type, address, data
//   d_ack, d_rdata              : load/store acknowledge pulse, loaded word
//   mem_addr, mem_wdata, mem_we : memory address, write data, write enable
//   mem_rdata                   : asynchronous memory read data
//   busy                        : a transaction is in ACCESS or DONE
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_t        state;
  arb_state_t        nextState;

  logic [ADDR_W-1:0] latchAddr;
  logic [DATA_W-1:0] latchWdata;
  logic              latchWe;
  logic              latchId;

  logic              starved;
  logic              anyReq;
  logic              grantI;
  logic              takeReq;
  logic              cntInc;
  logic              cntClr;

  // Arbitration. D wins whenever it asks, except when I has been waiting
  // long enough to be starved. The decision only takes effect in IDLE.
  assign anyReq  = i_req | d_req;
  assign grantI  = i_req & (~d_req | starved);
  assign takeReq = (state == IDLE) & anyReq;
  assign cntInc  = takeReq & i_req & ~grantI;
  assign cntClr  = takeReq & grantI;

  arb_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) uStarve (
    .Clk     (Clk),
    .Reset   (Reset),
    .clr     (cntClr),
    .inc     (cntInc),
    .starved (starved)
  );

  // State register. Reset drops straight back to IDLE, so a transaction
  // interrupted by Reset never reaches DONE and is never acknowledged.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic. Only IDLE looks at the requests; ACCESS and DONE
  // are fixed single cycles, which is what gives the 3-cycle cadence.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    nextState = anyReq ? ACCESS : IDLE;
      ACCESS:  nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output decode. Everything here depends only on the state register and
  // the latched transaction, so no request input reaches an output
  // combinationally. Because mem_we is decoded from state, a store whose
  // ACCESS cycle lines up with Reset still writes at that edge.
  always_comb begin
    mem_we = 1'b0;
    i_ack  = 1'b0;
    d_ack  = 1'b0;
    busy   = 1'b0;
    unique case (state)
      ACCESS: begin
        mem_we = latchWe & (latchId == PORT_D);
        busy   = 1'b1;
      end
      DONE: begin
        i_ack = (latchId == PORT_I);
        d_ack = (latchId == PORT_D);
        busy  = 1'b1;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  // Transaction latch and read-data capture. The winner's payload is
  // latched on the IDLE edge; a fetch latches we=0 and zero write data so
  // the memory bus never carries a stale store. In ACCESS the asynchronous
  // memory data is captured into the winner's read register, which also
  // holds a defined value after a store.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      latchAddr  <= '0;
      latchWdata <= '0;
      latchWe    <= 1'b0;
      latchId    <= PORT_I;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      if (takeReq) begin
        latchId    <= grantI ? PORT_I : PORT_D;
        latchAddr  <= grantI ? i_addr : d_addr;
        latchWe    <= grantI ? 1'b0 : d_we;
        latchWdata <= grantI ? '0 : d_wdata;
      end
      if (state == ACCESS) begin
        if (latchId == PORT_D) begin
          d_rdata <= mem_rdata;
        end else begin
          i_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_addr  = latchAddr;
  assign mem_wdata = latchWdata;

endmodule
